fifo_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares the single write port of the FIFO (16-bit, depth 8) between NUM_REQ producers.
- Selects one requester per cycle and drives a registered wr_en/data_in pair into the FIFO.
- Throttles on full/almostfull so a correctly sized FIFO never overflows.
- Routes the FIFO's wr_ack/overflow response back to the requester that owned the write; sits between producer blocks and the FIFO DUT port.

---
 rtl/fifo_wr_arbiter_if.sv | 29 ++
 rtl/fifo_wr_arbiter.sv | 116 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of requester-side and FIFO-write-side signals for fifo_wr_arbiter.
// The master modport is the arbiter view; slave is the producers-plus-FIFO view.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            done;
  logic [NUM_REQ-1:0]            drop;
  logic                          err_sticky;
  logic                          fifo_full;
  logic                          fifo_almostfull;
  logic                          fifo_wr_ack;
  logic                          fifo_overflow;
  logic                          fifo_wr_en;
  logic [FIFO_WIDTH-1:0]         fifo_data_in;

  modport master (
    input  req, req_data, fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow,
    output gnt, done, drop, err_sticky, fifo_wr_en, fifo_data_in
  );

  modport slave (
    output req, req_data, fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow,
    input  gnt, done, drop, err_sticky, fifo_wr_en, fifo_data_in
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// throttled on full/almostfull, with wr_ack/overflow routed back to the owner.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int IDW        = $clog2(NUM_REQ)
) (
  input logic               clk,
  input logic               rst,
  fifo_wr_arbiter_if.master bus
);
  localparam logic [IDW:0]   NREQ_L  = (IDW+1)'(NUM_REQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);

  logic [FIFO_WIDTH-1:0] req_arr_s [NUM_REQ];
  logic [IDW:0]          sum_s;
  logic [IDW-1:0]        cand_s;
  logic                  hit_s;
  logic                  win_vld_s;
  logic [IDW-1:0]        win_id_s;
  logic                  can_issue_s;
  logic                  grant_s;
  logic [NUM_REQ-1:0]    gnt_s;
  logic [NUM_REQ-1:0]    done_s;
  logic [NUM_REQ-1:0]    drop_s;

  logic [IDW-1:0]        ptr_r;
  logic                  wr_en_r;
  logic [FIFO_WIDTH-1:0] data_r;
  logic [IDW-1:0]        own_b_r;
  logic [IDW-1:0]        own_c_r;
  logic                  vld_c_r;
  logic                  err_r;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign req_arr_s[i] = bus.req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
  end

  // Rotating priority search: first set req bit at or above ptr, wrapping to 0.
  always_comb begin
    win_vld_s = 1'b0;
    win_id_s  = '0;
    sum_s     = '0;
    cand_s    = '0;
    hit_s     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s     = {1'b0, ptr_r} + k[IDW:0];
      cand_s    = (sum_s >= NREQ_L) ? IDW'(sum_s - NREQ_L) : sum_s[IDW-1:0];
      hit_s     = !win_vld_s && bus.req[cand_s];
      win_id_s  = hit_s ? cand_s : win_id_s;
      win_vld_s = win_vld_s | bus.req[cand_s];
    end
  end

  // An in-flight write plus almostfull means the last slot is already spoken for.
  assign can_issue_s = !bus.fifo_full && !(wr_en_r && bus.fifo_almostfull);
  assign grant_s     = !rst && can_issue_s && win_vld_s;

  // One-hot grant pulse to the winner.
  always_comb begin
    gnt_s = '0;
    if (grant_s) begin
      gnt_s[win_id_s] = 1'b1;
    end else begin
      gnt_s = '0;
    end
  end

  // Response routing; overflow wins if the FIFO ever raises both.
  always_comb begin
    done_s = '0;
    drop_s = '0;
    if (!rst && vld_c_r && bus.fifo_overflow) begin
      drop_s[own_c_r] = 1'b1;
    end else if (!rst && vld_c_r && bus.fifo_wr_ack) begin
      done_s[own_c_r] = 1'b1;
    end else begin
      done_s = '0;
      drop_s = '0;
    end
  end

  // Issue and response pipeline registers plus the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r   <= '0;
      wr_en_r <= 1'b0;
      data_r  <= '0;
      own_b_r <= '0;
      own_c_r <= '0;
      vld_c_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      if (grant_s) begin
        wr_en_r <= 1'b1;
        data_r  <= req_arr_s[win_id_s];
        own_b_r <= win_id_s;
        ptr_r   <= (win_id_s == LAST_ID) ? '0 : win_id_s + 1'b1;
      end else begin
        wr_en_r <= 1'b0;
      end
      own_c_r <= own_b_r;
      vld_c_r <= wr_en_r;
      if (vld_c_r && bus.fifo_overflow) begin
        err_r <= 1'b1;
      end
    end
  end

  assign bus.gnt          = gnt_s;
  assign bus.done         = done_s;
  assign bus.drop         = drop_s;
  assign bus.err_sticky   = err_r;
  assign bus.fifo_wr_en   = wr_en_r;
  assign bus.fifo_data_in = data_r;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a depth-8 FIFO stand-in and a
// queue scoreboard of issued data and write owners.
module tb_fifo_wr_arbiter;
  localparam int N = 4;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  logic rd_en;
  logic inj;
  logic [3:0] f_cnt;
  logic f_wr_ok;
  logic f_rd_ok;

  int vec_cnt = 0;
  int miscompares = 0;
  int done_cnt = 0;

  int m_ptr = 0;
  logic m_wr_en = 1'b0;
  logic m_vld_c = 1'b0;
  logic m_err = 1'b0;
  logic [N-1:0] last_gnt = '0;
  logic [W-1:0] data_q[$];
  int own_q[$];

  fifo_wr_arbiter_if #(.NUM_REQ(N), .FIFO_WIDTH(W)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  // FIFO stand-in: depth 8, ack/overflow registered one cycle after the write edge.
  assign bus.fifo_full       = (f_cnt == 4'd8);
  assign bus.fifo_almostfull = (f_cnt == 4'd7);
  assign f_wr_ok = bus.fifo_wr_en && !bus.fifo_full && !inj;
  assign f_rd_ok = rd_en && (f_cnt != 4'd0);

  always @(posedge clk) begin
    if (rst) begin
      f_cnt             <= 4'd0;
      bus.fifo_wr_ack   <= 1'b0;
      bus.fifo_overflow <= 1'b0;
    end else begin
      f_cnt             <= f_cnt + {3'd0, f_wr_ok} - {3'd0, f_rd_ok};
      bus.fifo_wr_ack   <= f_wr_ok;
      bus.fifo_overflow <= bus.fifo_wr_en && (bus.fifo_full || inj);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check at negedge against the model, then advance the model.
  task automatic tick();
    logic [N-1:0] e_gnt;
    logic [N-1:0] e_done;
    logic [N-1:0] e_drop;
    logic can;
    logic hit;
    logic ovf_seen;
    int w;
    int own;
    logic [W-1:0] d;
    @(negedge clk);
    can = !rst && !bus.fifo_full && !(m_wr_en && bus.fifo_almostfull);
    hit = 1'b0;
    w = 0;
    e_gnt = '0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (can && !hit && bus.req[j]) begin
        hit = 1'b1;
        w = j;
      end
    end
    if (hit) e_gnt[w] = 1'b1;
    chk("gnt", {28'd0, bus.gnt}, {28'd0, e_gnt});
    chk("wr_en", {31'd0, bus.fifo_wr_en}, {31'd0, m_wr_en});
    if (m_wr_en) begin
      if (data_q.size() > 0) begin
        d = data_q.pop_front();
        chk("data_in", {16'd0, bus.fifo_data_in}, {16'd0, d});
      end else begin
        chk("data_q_empty", 32'd0, 32'd1);
      end
    end
    e_done = '0;
    e_drop = '0;
    if (m_vld_c && own_q.size() > 0) begin
      own = own_q.pop_front();
      if (!rst && bus.fifo_overflow) e_drop[own] = 1'b1;
      else if (!rst && bus.fifo_wr_ack) e_done[own] = 1'b1;
    end
    chk("done", {28'd0, bus.done}, {28'd0, e_done});
    chk("drop", {28'd0, bus.drop}, {28'd0, e_drop});
    chk("err_sticky", {31'd0, bus.err_sticky}, {31'd0, m_err});
    done_cnt += $countones(bus.done);
    ovf_seen = m_vld_c && bus.fifo_overflow;
    if (hit) begin
      data_q.push_back(bus.req_data[w*W +: W]);
      own_q.push_back(w);
    end
    @(posedge clk);
    if (rst) begin
      m_ptr   = 0;
      m_wr_en = 1'b0;
      m_vld_c = 1'b0;
      m_err   = 1'b0;
      data_q.delete();
      own_q.delete();
    end else begin
      if (ovf_seen) m_err = 1'b1;
      m_vld_c = m_wr_en;
      m_wr_en = hit;
      if (hit) m_ptr = (w + 1) % N;
    end
    last_gnt = e_gnt;
    #1;
  endtask

  initial begin
    int nxt;
    rst          = 1'b1;
    rd_en        = 1'b1;
    inj          = 1'b0;
    bus.req      = 4'b1111;
    bus.req_data = {16'hD003, 16'hC002, 16'hB001, 16'hA000};
    @(posedge clk);
    #1;
    tick();
    rst = 1'b0;

    // Round robin with all four requesting and the FIFO draining.
    for (int c = 0; c < 6; c++) tick();
    chk("rr_last_gnt", {28'd0, last_gnt}, 32'h2);

    // Sparse requesters 1 and 3.
    bus.req = 4'b1010;
    for (int c = 0; c < 6; c++) tick();
    bus.req = 4'b0000;
    for (int c = 0; c < 3; c++) tick();

    // Full throttle: no reads, requester 0 offers 1..10.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd_en = 1'b0;
    done_cnt = 0;
    nxt = 1;
    for (int c = 0; c < 16; c++) begin
      bus.req_data[15:0] = 16'(nxt);
      bus.req = (nxt <= 10) ? 4'b0001 : 4'b0000;
      tick();
      if (last_gnt[0]) nxt++;
    end
    chk("full_acks", done_cnt, 32'd8);
    chk("full_issued", nxt, 32'd9);
    chk("full_flag", {31'd0, bus.fifo_full}, 32'd1);
    chk("full_no_err", {31'd0, bus.err_sticky}, 32'd0);

    // Forced overflow on requester 2's write.
    rst = 1'b1;
    bus.req = 4'b0000;
    tick();
    rst = 1'b0;
    rd_en = 1'b1;
    inj = 1'b1;
    bus.req = 4'b0100;
    tick();
    bus.req = 4'b0000;
    for (int c = 0; c < 5; c++) tick();
    inj = 1'b0;
    chk("ovf_err_held", {31'd0, bus.err_sticky}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Reset while port 1's write is in flight.
    bus.req = 4'b0010;
    tick();
    rst = 1'b1;
    bus.req = 4'b1111;
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_gnt", {28'd0, last_gnt}, 32'h1);
    bus.req = 4'b0000;
    for (int c = 0; c < 4; c++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end
endmodule
